// File: rtl/imem_loader_pkg.sv
// Shared definitions for the byte-wide instruction RAM and its loader:
// default geometry, byte-lane ordering within a word, and the loader state encoding.
package imem_loader_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DEPTH  = 256;
    localparam int BYTES_PER_WORD = 4;

    // Words are big-endian in memory: byte 0 (lowest address) carries bits 31:24.
    localparam bit BYTE0_IS_MSB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WR0    = 3'd2,
        ST_WR1    = 3'd3,
        ST_WR2    = 3'd4,
        ST_WR3    = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Byte of a word stored at offset 'lane' from the word address.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Instruction RAM loader: accepts 32-bit words on a valid/ready stream and
// writes each one as four consecutive byte writes, MSB first, from a
// word-aligned base address. A session ends on the word flagged last, or
// with overflow when the pointer would wrap past the top of the RAM.
//
// state  | meaning
// IDLE   | no session since reset; waiting for start
// ACCEPT | in_ready high; waiting for the next word
// WR0-3  | writing byte lane 0..3 of the captured word
// DONE   | session finished; done held until the next start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-2:0] word_count
);

    // The counter covers 0..DEPTH/4-1 and wraps there; the port is one bit
    // wider, so its MSB is always zero.
    localparam int CNT_W = ADDR_W - 2;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    // State and datapath registers; reset aborts any partial word in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        word_d  = word_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ACCEPT;
                    ptr_d   = base_addr & ~ADDR_W'(3);
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    word_d  = in_data;
                    last_d  = in_last;
                    state_d = ST_WR0;
                end
            end
            ST_WR0: state_d = ST_WR1;
            ST_WR1: state_d = ST_WR2;
            ST_WR2: state_d = ST_WR3;
            ST_WR3: begin
                ptr_d = ptr_q + ADDR_W'(BYTES_PER_WORD);
                cnt_d = cnt_q + CNT_W'(1);
                if (last_q) begin
                    state_d = ST_DONE;
                end else if (ptr_q == ADDR_W'(DEPTH - BYTES_PER_WORD)) begin
                    // The next word would start at address 0: stop instead of wrapping.
                    state_d = ST_DONE;
                    ovf_d   = 1'b1;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-port values for the state being entered, so they register on that edge.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_d)
            ST_WR0: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = {ptr_q[ADDR_W-1:2], 2'd0};
                mem_wdata_d = word_byte(word_d, 2'd0);
            end
            ST_WR1: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = {ptr_q[ADDR_W-1:2], 2'd1};
                mem_wdata_d = word_byte(word_d, 2'd1);
            end
            ST_WR2: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = {ptr_q[ADDR_W-1:2], 2'd2};
                mem_wdata_d = word_byte(word_d, 2'd2);
            end
            ST_WR3: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = {ptr_q[ADDR_W-1:2], 2'd3};
                mem_wdata_d = word_byte(word_d, 2'd3);
            end
            default: ;
        endcase
    end

    // Registered RAM write port; address and data hold while mem_we is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready   = (state_q == ST_ACCEPT);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign overflow   = ovf_q;
    assign word_count = {1'b0, cnt_q};
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-wide 256x8 instruction RAM that the CPU fetch path reads as 32-bit big-endian words (word at A = Mem[A..A+3], Mem[A] = bits 31:24).
- Accepts 32-bit instruction words over a valid/ready stream (e.g. from a boot/UART front end) and writes them byte-serially into the RAM from a word-aligned base address.
- Replaces file-based preloading for on-chip program load; the fetch side is unchanged.

Parameters:
- ADDR_W, 8, RAM byte-address width.
- DEPTH, 256, RAM size in bytes; must equal 2**ADDR_W and be a multiple of 4.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- base_addr  input  ADDR_W  start byte address, sampled on start; bits 1:0 are forced to 0.
- in_valid  input  1  input word valid.
- in_data  input  32  instruction word.
- in_last  input  1  qualifies the final word of the session; sampled with the handshake.
- in_ready  output  1  loader can accept a word.
- mem_we  output  1  byte write strobe to the RAM.
- mem_addr  output  ADDR_W  byte write address.
- mem_wdata  output  8  byte write data.
- busy  output  1  session in progress (any state except IDLE/DONE).
- done  output  1  session finished; level, held until the next start.
- overflow  output  1  session ended by address wrap; valid when done=1.
- word_count  output  ADDR_W-1  words written in the current or last session.

Behaviour:
- Reset: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, word_count=0, internal word register=0.
- Reset is asynchronous, so assertion mid-session aborts immediately. A partially written word stays partially written, with no cleanup.
- States:
  - IDLE: in_ready=0.
    - start -> ACCEPT.
    - Load ptr = {base_addr[ADDR_W-1:2],2'b00}; clear word_count, done and overflow.
  - ACCEPT: in_ready=1.
    - in_valid&in_ready -> capture in_data and in_last -> WR0.
  - WR0..WR3: mem_we=1, mem_addr=ptr+k (k=0..3).
    - mem_wdata: WR0=bits 31:24, WR1=23:16, WR2=15:8, WR3=7:0.
    - One byte per cycle; outputs are registered and change on the clock edge entering each state.
  - After WR3: ptr+=4 (mod DEPTH), word_count+=1.
    - Captured last=1 -> DONE.
    - Else ptr wrapped to 0 -> DONE with overflow=1.
    - Else -> ACCEPT.
  - DONE: done=1, in_ready=0, mem_we=0.
    - start -> same as start in IDLE (done cleared on that edge).
- Throughput: 5 cycles per word (1 accept + 4 writes). A word is accepted in the cycle in_valid&in_ready are both high; the first byte write is visible on the next cycle.
- in_ready is low in WR0..WR3, IDLE and DONE. in_valid in those states is ignored and not lost; the producer holds it.
- start while busy=1: ignored.
- start and in_valid asserted in the same cycle in IDLE: only start is taken; the word is accepted next cycle.
- mem_addr/mem_wdata hold their last values when mem_we=0; the RAM must gate on mem_we.
- Wrap: the last legal word is at DEPTH-4. Writing it with in_last=0 sets overflow; no write ever targets an address at or above DEPTH.
- word_count width is ADDR_W-1, i.e. 0..DEPTH/4-1 counted. A full 64-word session wraps the count to 0, so overflow=1 disambiguates.

Decomposition:
- Shared package (the one the RAM models use): the endianness convention (byte 0 = MSB), DEFAULT_ADDR_W=8, DEFAULT_DEPTH=256, and the state encoding (IDLE, ACCEPT, WR0..WR3, DONE, 3-bit).
- No sub-module: single FSM with datapath registers.
- The testbench instantiates the existing 256x8 RAM with a write-port wrapper and reads back through its Enable/Address/DataOut port.

Test Plan:
- Reset then idle: no start, 20 cycles -> mem_we never 1, in_ready=0, done=0, all outputs 0.
- Single word: start, base_addr=0x10, word 0xE3A01005 with in_last=1 -> writes E3@0x10, A0@0x11, 10@0x12, 05@0x13 on consecutive cycles. done=1, word_count=1, overflow=0; RAM readback at 0x10 = E3A01005.
- Stream with stalls: base 0x00, 3 words; in_valid dropped 2 cycles between words; valid asserted during WR states -> no word lost or duplicated. Addresses 0x00..0x0B written, word_count=3; readback matches.
- Misaligned base and wrap: base_addr=0xFB (forced to 0xF8), 3 words, none with in_last -> words at 0xF8 and 0xFC written. Session ends after the second word with done=1, overflow=1, word_count=2; the third word is never accepted and address 0x00 is untouched.
- Mid-session reset: assert reset_n=0 during WR2 of the second word -> outputs immediately at reset values, state IDLE. A new start from 0x40 loads correctly afterwards.
- start while busy: pulse start with base 0x80 during WR1 -> ignored; the session continues at its original addresses.
